// File: rtl/alu_divider_if.sv
// Handshake and operand/result bundle for the sequential 8/4 divider.
// The slave side is the divider; the master side is the launching FSM.
interface alu_divider_if;
    logic       i_start;
    logic [7:0] i_dividend;
    logic [3:0] i_divisor;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_quotient;
    logic [3:0] o_remainder;
    logic       o_div_by_zero;

    modport master (
        output i_start, i_dividend, i_divisor,
        input  o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
    );

    modport slave (
        input  i_start, i_dividend, i_divisor,
        output o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
    );
endinterface

// File: rtl/alu_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Zero divisor short-circuits to DONE with all-ones results and the div_by_zero flag.
module alu_divider (
    input  logic          clk,
    input  logic          rst,
    alu_divider_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e     r_state,     w_state_next;
    logic [7:0] r_dividend,  w_dividend_next;
    logic [3:0] r_divisor,   w_divisor_next;
    logic [3:0] r_p,         w_p_next;
    logic [2:0] r_count,     w_count_next;
    logic [7:0] r_qshift,    w_qshift_next;
    logic [7:0] r_quotient,  w_quotient_next;
    logic [3:0] r_remainder, w_remainder_next;
    logic       r_dbz,       w_dbz_next;

    logic [4:0] w_t;
    logic       w_ge;
    logic [3:0] w_p_new;

    // p[4] only exists inside the trial value; after the restore step it always fits in 4 bits.
    assign w_t     = {r_p, r_dividend[7]};
    assign w_ge    = (w_t >= {1'b0, r_divisor});
    assign w_p_new = w_ge ? 4'(w_t - {1'b0, r_divisor}) : w_t[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_dividend  <= 8'h00;
            r_divisor   <= 4'h0;
            r_p         <= 4'h0;
            r_count     <= 3'd0;
            r_qshift    <= 8'h00;
            r_quotient  <= 8'h00;
            r_remainder <= 4'h0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dividend  <= w_dividend_next;
            r_divisor   <= w_divisor_next;
            r_p         <= w_p_next;
            r_count     <= w_count_next;
            r_qshift    <= w_qshift_next;
            r_quotient  <= w_quotient_next;
            r_remainder <= w_remainder_next;
            r_dbz       <= w_dbz_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_dividend_next  = r_dividend;
        w_divisor_next   = r_divisor;
        w_p_next         = r_p;
        w_count_next     = r_count;
        w_qshift_next    = r_qshift;
        w_quotient_next  = r_quotient;
        w_remainder_next = r_remainder;
        w_dbz_next       = r_dbz;

        unique case (r_state)
            StIdle: begin
                if (bus.i_start) begin
                    w_dividend_next = bus.i_dividend;
                    w_divisor_next  = bus.i_divisor;
                    if (bus.i_divisor != 4'h0) begin
                        w_p_next      = 4'h0;
                        w_count_next  = 3'd7;
                        w_qshift_next = 8'h00;
                        w_dbz_next    = 1'b0;
                        w_state_next  = StCalc;
                    end else begin
                        w_quotient_next  = 8'hFF;
                        w_remainder_next = 4'hF;
                        w_dbz_next       = 1'b1;
                        w_state_next     = StDone;
                    end
                end
            end
            StCalc: begin
                w_dividend_next = {r_dividend[6:0], 1'b0};
                w_p_next        = w_p_new;
                w_qshift_next   = {r_qshift[6:0], w_ge};
                if (r_count == 3'd0) begin
                    w_quotient_next  = {r_qshift[6:0], w_ge};
                    w_remainder_next = w_p_new;
                    w_state_next     = StDone;
                end else begin
                    w_count_next = r_count - 3'd1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign bus.o_busy        = (r_state == StCalc);
    assign bus.o_done        = (r_state == StDone);
    assign bus.o_quotient    = r_quotient;
    assign bus.o_remainder   = r_remainder;
    assign bus.o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: directed corners plus random operands,
// checked against plain integer division.
module tb_alu_divider;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_divider_if bus ();

    alu_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if ({bus.o_busy, bus.o_done, bus.o_quotient, bus.o_remainder, bus.o_div_by_zero} !== 15'd0) begin
            n_fail++;
            $display("FAIL %s: busy=%b done=%b q=%0d r=%0d dbz=%b, required all zero", name,
                     bus.o_busy, bus.o_done, bus.o_quotient, bus.o_remainder, bus.o_div_by_zero);
        end
    endtask

    // Launch one division, follow it to done and compare against integer division.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b, input string name);
        int         busy_cnt;
        int         waited;
        logic [7:0] exp_q;
        logic [3:0] exp_r;
        logic       exp_z;
        int         exp_busy;
        busy_cnt = 0;
        waited   = 0;
        if (b == 0) begin
            exp_q = 8'hFF; exp_r = 4'hF; exp_z = 1'b1; exp_busy = 0;
        end else begin
            exp_q = 8'(int'(a) / int'(b));
            exp_r = 4'(int'(a) % int'(b));
            exp_z = 1'b0;
            exp_busy = 8;
        end
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_start    = 1'b1;
        tick();
        bus.i_start = 1'b0;
        while (!bus.o_done && waited < 20) begin
            if (bus.o_busy) busy_cnt++;
            tick();
            waited++;
        end
        n_checks++;
        if (bus.o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, bus.o_done, waited);
        end
        n_checks++;
        if (busy_cnt != exp_busy) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d, required %0d", name, busy_cnt, exp_busy);
        end
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_with_done: busy=%b, required 0", name, bus.o_busy);
        end
        n_checks++;
        if ({bus.o_quotient, bus.o_remainder, bus.o_div_by_zero} !== {exp_q, exp_r, exp_z}) begin
            n_fail++;
            $display("FAIL %s_result (%0d/%0d): q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                     name, a, b, bus.o_quotient, bus.o_remainder, bus.o_div_by_zero,
                     exp_q, exp_r, exp_z);
        end
        tick();
        n_checks++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done=%b busy=%b one cycle later, required 0/0", name,
                     bus.o_done, bus.o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_dividend = 8'h00;
        bus.i_divisor  = 4'h0;
        #1;
        check_outputs_zero("reset_state");
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        check_outputs_zero("after_reset_release");
    endtask

    task automatic test_basic();
        run_div(8'd200, 4'd7, "basic_200_7");
    endtask

    task automatic test_corners();
        logic [7:0] q0;
        logic [3:0] r0;
        run_div(8'd255, 4'd1, "c_255_1");
        run_div(8'd9, 4'd15, "c_9_15");
        run_div(8'd0, 4'd5, "c_0_5");
        run_div(8'd255, 4'd15, "c_255_15");
        q0 = bus.o_quotient;
        r0 = bus.o_remainder;
        bus.i_dividend = 8'd3;
        bus.i_divisor  = 4'd2;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (bus.o_quotient !== 8'd17 || bus.o_remainder !== 4'd0 || bus.o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: q=%0d r=%0d done=%b, required q=17 r=0 done=0 (was %0d/%0d)",
                         i, bus.o_quotient, bus.o_remainder, bus.o_done, q0, r0);
            end
        end
    endtask

    task automatic test_div_by_zero();
        run_div(8'd100, 4'd0, "dbz_100_0");
        run_div(8'd100, 4'd3, "after_dbz_100_3");
    endtask

    task automatic test_ignore_start();
        int waited;
        int extra_done;
        waited = 0;
        extra_done = 0;
        bus.i_dividend = 8'd200;
        bus.i_divisor  = 4'd7;
        bus.i_start    = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick();
        tick();
        bus.i_dividend = 8'd50;
        bus.i_divisor  = 4'd5;
        bus.i_start    = 1'b1;
        tick();
        bus.i_start    = 1'b0;
        bus.i_dividend = 8'd17;
        bus.i_divisor  = 4'd0;
        while (!bus.o_done && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (bus.o_done !== 1'b1 || bus.o_quotient !== 8'd28 || bus.o_remainder !== 4'd4 ||
            bus.o_div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_result: done=%b q=%0d r=%0d dbz=%b, required 1/28/4/0",
                     bus.o_done, bus.o_quotient, bus.o_remainder, bus.o_div_by_zero);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.o_done || bus.o_busy) extra_done++;
        end
        n_checks++;
        if (extra_done != 0 || bus.o_quotient !== 8'd28) begin
            n_fail++;
            $display("FAIL ignore_start_trace: %0d extra busy/done cycles q=%0d, required 0 and 28",
                     extra_done, bus.o_quotient);
        end
    endtask

    task automatic test_reset_mid_calc();
        int seen_done;
        seen_done = 0;
        bus.i_dividend = 8'd200;
        bus.i_divisor  = 4'd7;
        bus.i_start    = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_calc_busy: busy=%b, required 1", bus.o_busy);
        end
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("async_reset_mid_calc");
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.o_done) seen_done++;
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.o_done) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL reset_abandon: %0d done cycles seen, required 0", seen_done);
        end
        run_div(8'd13, 4'd4, "after_reset_13_4");
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [3:0] b;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            b = 4'($urandom_range(0, 15));
            run_div(a, b, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        int last_done;
        int bad_gap;
        n_done    = 0;
        last_done = -1;
        bad_gap   = 0;
        bus.i_dividend = 8'd255;
        bus.i_divisor  = 4'd2;
        bus.i_start    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            n_checks++;
            if (bus.o_busy && bus.o_done) begin
                n_fail++;
                $display("FAIL b2b_overlap cycle%0d: busy=1 done=1, required not both", k);
            end
            if (bus.o_done) begin
                n_done++;
                if (last_done >= 0 && k - last_done != 10) bad_gap++;
                last_done = k;
                n_checks++;
                if (bus.o_quotient !== 8'd127 || bus.o_remainder !== 4'd1) begin
                    n_fail++;
                    $display("FAIL b2b_result cycle%0d: q=%0d r=%0d, required q=127 r=1", k,
                             bus.o_quotient, bus.o_remainder);
                end
            end
        end
        bus.i_start = 1'b0;
        n_checks++;
        if (n_done != 4 || bad_gap != 0) begin
            n_fail++;
            $display("FAIL b2b_throughput: %0d dones, %0d bad gaps, required 4 dones 0 bad gaps",
                     n_done, bad_gap);
        end
        tick();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_corners();
        test_div_by_zero();
        test_ignore_start();
        test_reset_mid_calc();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
